// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port unified memory between the instruction-fetch port
//   and the load/store data port.
//
//   Arbitration
//     - Data has priority.
//     - If a fetch has waited through MAX_DATA_STREAK data grants, the fetch
//       is forced through.
//
//   Responses
//     - Each accepted request gets a registered one-cycle response pulse.
//
//   Sub-word stores
//     - The memory has no byte enables.
//     - A store with partial strobes therefore becomes a two-cycle
//       read-modify-write.
//
//   Ports
//     clk, rst_n                       clock, asynchronous active-low reset
//     if_req_valid/addr, if_req_ready  fetch request handshake
//     if_resp_valid/rdata              fetch response (1-cycle pulse)
//     d_req_valid/we/addr/wstrb/wdata  data request
//     d_req_ready                      data request accepted this cycle
//     d_resp_valid/rdata               data response (rdata=0 for stores)
//     mem_we/addr/wdata, mem_rdata     memory port (combinational read)
module mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_rdata,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [3:0]        d_req_wstrb,
  input  logic [31:0]       d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [31:0]       d_resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RMW  = 1'b1;

  logic [0:0]        state_reg;
  logic [SW-1:0]     streak_reg;
  logic [ADDR_W-1:0] rmw_addr_reg;
  logic [31:0]       rmw_data_reg;

  logic        grant_d;
  logic        grant_f;
  logic        starve;
  logic        strb_full;
  logic        strb_none;
  logic        strb_partial;
  logic [31:0] merged;

  assign starve       = if_req_valid && (streak_reg == STREAK_MAX);
  assign strb_full    = &d_req_wstrb;
  assign strb_none    = ~|d_req_wstrb;
  assign strb_partial = !strb_full && !strb_none;

  // Merge the store bytes over the current memory word, lane by lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = d_req_wstrb[gi] ? d_req_wdata[gi*8 +: 8]
                                                 : mem_rdata[gi*8 +: 8];
    end
  endgenerate

  // Grants only happen in IDLE.
  // They are held off while reset is asserted, so the readys read 0 then.
  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (rst_n && (state_reg == IDLE)) begin
      if (d_req_valid && !starve) begin
        grant_d = 1'b1;
      end else if (if_req_valid) begin
        grant_f = 1'b1;
      end
    end
  end

  assign if_req_ready = grant_f;
  assign d_req_ready  = grant_d;

  // Memory port.
  // Gating with rst_n makes a reset in the middle of an RMW drop the write at
  // once, without waiting for a clock edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (state_reg == RMW) begin
        mem_we    = 1'b1;
        mem_addr  = rmw_addr_reg;
        mem_wdata = rmw_data_reg;
      end else if (grant_d) begin
        mem_addr = d_req_addr;
        if (d_req_we && strb_full) begin
          mem_we    = 1'b1;
          mem_wdata = d_req_wdata;
        end
      end else if (grant_f) begin
        mem_addr = if_req_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      rmw_addr_reg  <= '0;
      rmw_data_reg  <= '0;
      if_resp_valid <= 1'b0;
      if_resp_rdata <= '0;
      d_resp_valid  <= 1'b0;
      d_resp_rdata  <= '0;
    end else begin
      if_resp_valid <= grant_f;
      if (grant_f) begin
        if_resp_rdata <= mem_rdata;
      end

      d_resp_valid <= 1'b0;
      if (state_reg == RMW) begin
        d_resp_valid <= 1'b1;
        d_resp_rdata <= '0;
        state_reg    <= IDLE;
      end else if (grant_d) begin
        if (!d_req_we) begin
          d_resp_valid <= 1'b1;
          d_resp_rdata <= mem_rdata;
        end else if (strb_partial) begin
          // The write is issued in the next cycle.
          // The response follows after that write.
          state_reg    <= RMW;
          rmw_addr_reg <= d_req_addr;
          rmw_data_reg <= merged;
        end else begin
          // A full-word store or an all-zero-strobe store completes now.
          d_resp_valid <= 1'b1;
          d_resp_rdata <= '0;
        end
      end

      // Count data grants only while a fetch is actually waiting.
      if (!if_req_valid || grant_f) begin
        streak_reg <= '0;
      end else if (grant_d && (streak_reg != STREAK_MAX)) begin
        streak_reg <= streak_reg + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_rdata;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [3:0]  d_req_wstrb;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];

  logic [31:0] mem [0:2047];

  mem_arbiter #(.MAX_DATA_STREAK(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unified memory: combinational read, synchronous write.
  assign mem_rdata = mem[mem_addr[12:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[12:2]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response pulse is presented.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n === 1'b1) begin
      if (if_resp_valid) begin
        if (if_q.size() == 0) check("if_resp unexpected", 32'd1, 32'd0);
        else begin e = if_q.pop_front(); check("if_resp_rdata", if_resp_rdata, e); end
      end
      if (d_resp_valid) begin
        if (d_q.size() == 0) check("d_resp unexpected", 32'd1, 32'd0);
        else begin e = d_q.pop_front(); check("d_resp_rdata", d_resp_rdata, e); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd);
    d_req_valid = v; d_req_we = we; d_req_addr = a; d_req_wstrb = s; d_req_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[0]  = 32'h00000013;
    mem[1]  = 32'h00000093;
    mem[2]  = 32'hCAFEF00D;
    mem[8]  = 32'hA5A5A5A5;
    mem[64] = 32'h12345678;

    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    set_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick(); tick();
    // Reset state, with a fetch request present.
    check("reset if_req_ready", {31'd0, if_req_ready}, 32'd0);
    check("reset d_req_ready", {31'd0, d_req_ready}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset if_resp_valid", {31'd0, if_resp_valid}, 32'd0);
    check("reset d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
    check("reset if_resp_rdata", if_resp_rdata, 32'd0);
    if_req_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Back-to-back fetches.
    if_req_valid = 1'b1; if_req_addr = 32'h0; #1;
    check("fetch0 ready", {31'd0, if_req_ready}, 32'd1);
    if_q.push_back(32'h00000013);
    tick();
    if_req_addr = 32'h4; #1;
    check("fetch4 ready", {31'd0, if_req_ready}, 32'd1);
    check("fetch4 mem_addr", mem_addr, 32'h4);
    if_q.push_back(32'h00000093);
    tick();
    if_req_valid = 1'b0;
    tick();

    // Simultaneous fetch and load: data first.
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    set_d(1'b1, 1'b0, 32'h100, 4'h0, 32'h0); #1;
    check("simul d_req_ready", {31'd0, d_req_ready}, 32'd1);
    check("simul if_req_ready", {31'd0, if_req_ready}, 32'd0);
    d_q.push_back(32'h12345678);
    tick();
    d_req_valid = 1'b0; #1;
    check("simul d_resp first", {30'd0, d_resp_valid, if_resp_valid}, 32'd2);
    check("simul fetch next", {31'd0, if_req_ready}, 32'd1);
    if_q.push_back(32'hCAFEF00D);
    tick();
    if_req_valid = 1'b0;
    tick();

    // Full store then load.
    set_d(1'b1, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF); #1;
    check("fstore mem_we", {31'd0, mem_we}, 32'd1);
    check("fstore mem_wdata", mem_wdata, 32'hDEADBEEF);
    d_q.push_back(32'h0);
    tick();
    set_d(1'b1, 1'b0, 32'h40, 4'h0, 32'h0); #1;
    check("fstore mem_we pulse", {31'd0, mem_we}, 32'd0);
    d_q.push_back(32'hDEADBEEF);
    tick();
    d_req_valid = 1'b0;
    tick();

    // Read-modify-write with a fetch waiting.
    set_d(1'b1, 1'b1, 32'h40, 4'hF, 32'h11223344);
    d_q.push_back(32'h0);
    tick();
    set_d(1'b1, 1'b1, 32'h40, 4'b0010, 32'h0000AB00);
    if_req_valid = 1'b1; if_req_addr = 32'h0; #1;
    check("pstore d_req_ready", {31'd0, d_req_ready}, 32'd1);
    check("pstore accept mem_we", {31'd0, mem_we}, 32'd0);
    d_q.push_back(32'h0);
    tick();
    d_req_valid = 1'b0; #1;
    check("rmw readys", {30'd0, if_req_ready, d_req_ready}, 32'd0);
    check("rmw mem_we", {31'd0, mem_we}, 32'd1);
    check("rmw mem_addr", mem_addr, 32'h40);
    check("rmw mem_wdata", mem_wdata, 32'h1122AB44);
    check("rmw no resp yet", {31'd0, d_resp_valid}, 32'd0);
    tick();
    check("after rmw if_ready", {31'd0, if_req_ready}, 32'd1);
    if_q.push_back(32'h00000013);
    tick();
    if_req_valid = 1'b0;
    set_d(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    d_q.push_back(32'h1122AB44);
    tick();
    d_req_valid = 1'b0;
    tick();

    // Zero-strobe store: accepted, memory untouched.
    set_d(1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF); #1;
    check("zstore ready", {31'd0, d_req_ready}, 32'd1);
    check("zstore mem_we", {31'd0, mem_we}, 32'd0);
    d_q.push_back(32'h0);
    tick();
    set_d(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    d_q.push_back(32'hA5A5A5A5);
    tick();
    d_req_valid = 1'b0;
    tick();

    // Anti-starvation: fetch held, data continuous.
    if_req_valid = 1'b1; if_req_addr = 32'h4;
    set_d(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("streak data%0d", i), {30'd0, if_req_ready, d_req_ready}, 32'd1);
      d_q.push_back(32'h12345678);
      tick();
    end
    #1;
    check("streak forced fetch", {30'd0, if_req_ready, d_req_ready}, 32'd2);
    if_q.push_back(32'h00000093);
    tick();
    #1;
    check("streak cleared", {30'd0, if_req_ready, d_req_ready}, 32'd1);
    d_q.push_back(32'h12345678);
    tick();
    d_req_valid = 1'b0; #1;
    check("streak fetch again", {31'd0, if_req_ready}, 32'd1);
    if_q.push_back(32'h00000093);
    tick();
    if_req_valid = 1'b0;
    tick(); tick();

    // Reset in the middle of an RMW.
    set_d(1'b1, 1'b1, 32'h20, 4'b0001, 32'h000000FF); #1;
    check("rst-rmw accept", {31'd0, d_req_ready}, 32'd1);
    tick();
    d_req_valid = 1'b0; #1;
    check("rst-rmw in rmw", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0; #1;
    check("rst-rmw mem_we", {31'd0, mem_we}, 32'd0);
    check("rst-rmw mem_addr", mem_addr, 32'd0);
    check("rst-rmw mem_wdata", mem_wdata, 32'd0);
    check("rst-rmw d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
    check("rst-rmw d_resp_rdata", d_resp_rdata, 32'd0);
    tick();
    check("rst-rmw mem untouched", mem[8], 32'hA5A5A5A5);
    rst_n = 1'b1;
    tick();
    check("rst-rmw no late resp", {31'd0, d_resp_valid}, 32'd0);
    check("if_q drained", if_q.size(), 32'd0);
    check("d_q drained", d_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
